rx_slip_ctrl: RTL and testbench

Sequences the 64b/66b receive alignment loop between the RX gearbox and `block_sync_rx`. Turns each slip request into a one-bit gearbox offset step and masks the block-valid qualifier while the gearbox settles. Also tracks the lock state, flags acquisition timeouts and optionally counts slips. It sits between the gearbox output and `block_sync_rx`, and is the only writer of the gearbox bit offset.

---
 rtl/rx_slip_ctrl.sv | 152 +++++++++++++++
 tb/tb_rx_slip_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rx_slip_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_slip_ctrl
// Purpose  : 64b/66b RX alignment sequencer: slip -> gearbox offset step,
//            valid masking while the gearbox settles, lock/timeout tracking.
//            Optional slip counter built when RX_SLIP_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rx_slip_ctrl #(
  parameter int BLOCK_W   = 66,
  parameter int OFF_W     = 7,
  parameter int HOLDOFF   = 4,
  parameter int TIMEOUT_W = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             signal_v_i,
  input  logic             gb_valid_i,
  input  logic             slip_v_i,
  input  logic             lock_v_i,
  output logic             valid_o,
  output logic [OFF_W-1:0] offset_o,
  output logic             offset_v_o,
  output logic             lock_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] slip_cnt_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HUNT   = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  localparam int                HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] c_hold_init = HOLD_W'(HOLDOFF - 1);
  localparam logic [OFF_W-1:0]  c_off_last  = OFF_W'(BLOCK_W - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic                 w_slip_acc;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [OFF_W-1:0]     r_offset;
  logic                 r_offset_v;
  logic                 r_lock;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic                 r_timeout;
  logic                 w_to_clr;
  logic                 w_to_run;

  // Loss of signal overrides everything, including a same-cycle slip.
  always_comb begin
    w_next     = r_state;
    w_slip_acc = 1'b0;
    if (!signal_v_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_next = HUNT;
        HUNT: begin
          if (slip_v_i) begin
            w_slip_acc = 1'b1;
            w_next     = HOLD;
          end else if (lock_v_i) begin
            w_next = LOCKED;
          end
        end
        HOLD: if (r_hold_cnt == '0) w_next = HUNT;
        LOCKED: begin
          if (slip_v_i) begin
            w_slip_acc = 1'b1;
            w_next     = HOLD;
          end else if (!lock_v_i) begin
            w_next = HUNT;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  assign w_to_clr = signal_v_i && ((r_state == IDLE) || (r_state == LOCKED && w_next == HUNT));
  assign w_to_run = (r_state == HUNT) || (r_state == HOLD);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_offset   <= '0;
      r_offset_v <= 1'b0;
      r_lock     <= 1'b0;
      r_to_cnt   <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_lock  <= (w_next == LOCKED);

      if (w_slip_acc) begin
        r_hold_cnt <= c_hold_init;
      end else if (r_state == HOLD && r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end

      if (!signal_v_i) begin
        r_offset   <= '0;
        r_offset_v <= 1'b0;
      end else if (w_slip_acc) begin
        r_offset   <= (r_offset == c_off_last) ? '0 : r_offset + 1'b1;
        r_offset_v <= 1'b1;
      end else begin
        r_offset_v <= 1'b0;
      end

      // Timeout is informational: it wraps and pulses without touching the FSM.
      r_timeout <= 1'b0;
      if (w_to_clr) begin
        r_to_cnt <= '0;
      end else if (w_to_run) begin
        if (r_to_cnt == '1) begin
          r_to_cnt  <= '0;
          r_timeout <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

`ifdef RX_SLIP_CNT_EN
  logic [CNT_W-1:0] r_slip_cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_slip_cnt <= '0;
    end else if (w_slip_acc && r_slip_cnt != '1) begin
      r_slip_cnt <= r_slip_cnt + 1'b1;
    end
  end

  assign slip_cnt_o = r_slip_cnt;
`else
  assign slip_cnt_o = '0;
`endif

  assign valid_o    = ((r_state == HUNT) || (r_state == LOCKED)) && gb_valid_i;
  assign offset_o   = r_offset;
  assign offset_v_o = r_offset_v;
  assign lock_o     = r_lock;
  assign timeout_o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rx_slip_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_slip_ctrl
// Purpose  : Self-checking bench for rx_slip_ctrl (HOLDOFF=4, TIMEOUT_W=6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_slip_ctrl;

  localparam int OFF_W = 7;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             nreset;
  logic             signal_v_i, gb_valid_i, slip_v_i, lock_v_i;
  logic             valid_o, offset_v_o, lock_o, timeout_o;
  logic [OFF_W-1:0] offset_o;
  logic [CNT_W-1:0] slip_cnt_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             sig, gb, slip, lock;
    logic             ev;
    logic [OFF_W-1:0] eo;
    logic             eov, elk, eto;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[18];

  int               m_k;
  logic [OFF_W-1:0] m_off;

  rx_slip_ctrl #(
    .BLOCK_W(66), .OFF_W(OFF_W), .HOLDOFF(4), .TIMEOUT_W(6), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .nreset(nreset),
    .signal_v_i(signal_v_i), .gb_valid_i(gb_valid_i),
    .slip_v_i(slip_v_i), .lock_v_i(lock_v_i),
    .valid_o(valid_o), .offset_o(offset_o), .offset_v_o(offset_v_o),
    .lock_o(lock_o), .timeout_o(timeout_o), .slip_cnt_o(slip_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sig, gb, slip, lock, ev,
                              input logic [OFF_W-1:0] eo, input logic eov, elk, eto);
    vec_t v;
    v.sig = sig; v.gb = gb; v.slip = slip; v.lock = lock;
    v.ev = ev; v.eo = eo; v.eov = eov; v.elk = elk; v.eto = eto;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    signal_v_i = v.sig; gb_valid_i = v.gb; slip_v_i = v.slip; lock_v_i = v.lock;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("valid_o",    32'(valid_o),    32'(e.ev));
    chk("offset_o",   32'(offset_o),   32'(e.eo));
    chk("offset_v_o", 32'(offset_v_o), 32'(e.eov));
    chk("lock_o",     32'(lock_o),     32'(e.elk));
    chk("timeout_o",  32'(timeout_o),  32'(e.eto));
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0; signal_v_i = 1'b0; gb_valid_i = 1'b1; slip_v_i = 1'b0; lock_v_i = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    m_off = '0;
    m_k   = 0;
  endtask

  function automatic logic tp(input int k);
    return (k > 0) && (k % 64 == 0);
  endfunction

  task automatic sig_up();
    m_k = 0;
    step(mk(1, 1, 0, 0, 1, m_off, 0, 0, 0));
  endtask

  // One slip from HUNT, then five idle cycles: 4 masked HOLD cycles, 2 in HUNT.
  task automatic slip_group();
    for (int j = 0; j < 6; j++) begin
      m_k++;
      if (j == 0) m_off = (m_off == 7'd65) ? 7'd0 : m_off + 7'd1;
      step(mk(1, 1, (j == 0), 0, (j >= 4), m_off, (j == 0), 0, tp(m_k)));
    end
  endtask

  initial begin
    nreset = 1'b0; signal_v_i = 1'b0; gb_valid_i = 1'b1; slip_v_i = 1'b0; lock_v_i = 1'b0;
    m_off = '0; m_k = 0;

    //              sig gb sl lk  ev eo eov elk eto
    tbl[0]  = mk(1, 1, 0, 0,  1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 1,  0, 1, 1, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0,  0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 1, 1, 1,  0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0,  0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0,  1, 1, 0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 1,  1, 1, 0, 1, 0);
    tbl[8]  = mk(1, 0, 0, 1,  0, 1, 0, 1, 0);
    tbl[9]  = mk(1, 1, 1, 1,  0, 2, 1, 0, 0);
    tbl[10] = mk(1, 1, 0, 1,  0, 2, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 1,  0, 2, 0, 0, 0);
    tbl[12] = mk(1, 1, 0, 1,  0, 2, 0, 0, 0);
    tbl[13] = mk(1, 1, 0, 1,  1, 2, 0, 0, 0);
    tbl[14] = mk(1, 1, 0, 1,  1, 2, 0, 1, 0);
    tbl[15] = mk(1, 1, 0, 0,  1, 2, 0, 0, 0);
    tbl[16] = mk(0, 1, 1, 0,  0, 0, 0, 0, 0);
    tbl[17] = mk(1, 1, 0, 0,  1, 0, 0, 0, 0);

    do_reset();
    #1;
    chk("rst valid_o",    32'(valid_o),    0);
    chk("rst offset_o",   32'(offset_o),   0);
    chk("rst offset_v_o", 32'(offset_v_o), 0);
    chk("rst lock_o",     32'(lock_o),     0);
    chk("rst timeout_o",  32'(timeout_o),  0);
    chk("rst slip_cnt_o", 32'(slip_cnt_o), 0);

    for (int i = 0; i < 18; i++) step(tbl[i]);
`ifdef RX_SLIP_CNT_EN
    chk("slip_cnt table", 32'(slip_cnt_o), 2);
`else
    chk("slip_cnt table", 32'(slip_cnt_o), 0);
`endif

    // Asynchronous reset in the middle of HOLD, right after a slip.
    do_reset();
    sig_up();
    step(mk(1, 1, 1, 0, 0, 1, 1, 0, 0));
    #2;
    nreset = 1'b0;
    #1;
    chk("arst offset_o",   32'(offset_o),   0);
    chk("arst offset_v_o", 32'(offset_v_o), 0);
    chk("arst lock_o",     32'(lock_o),     0);
    chk("arst valid_o",    32'(valid_o),    0);
    chk("arst timeout_o",  32'(timeout_o),  0);
    chk("arst slip_cnt_o", 32'(slip_cnt_o), 0);

    // 66 spaced slips wrap the offset back to 0.
    do_reset();
    sig_up();
    for (int s = 0; s < 66; s++) slip_group();
    chk("wrap offset_o", 32'(offset_o), 0);
`ifdef RX_SLIP_CNT_EN
    chk("wrap slip_cnt", 32'(slip_cnt_o), 66);
`else
    chk("wrap slip_cnt", 32'(slip_cnt_o), 0);
`endif

    // Timeout: parked in HUNT, pulse every 64 cycles, offset untouched.
    do_reset();
    sig_up();
    for (int c = 0; c < 140; c++) begin
      m_k++;
      step(mk(1, 1, 0, 0, 1, 0, 0, 0, tp(m_k)));
    end

    // Signal loss while LOCKED at offset 37, with a simultaneous slip.
    do_reset();
    sig_up();
    for (int s = 0; s < 37; s++) slip_group();
    m_k++;
    step(mk(1, 1, 0, 1, 1, 37, 0, 1, tp(m_k)));
    step(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
